// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared types and helpers for the PRBS link-test blocks.
// Revision : 1.0
// ============================================================================
package lfsr_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN
   } prbs_ctrl_state_t;

   localparam int POP_MAX_W = 64;

   function automatic logic [6:0] popcount(input logic [POP_MAX_W-1:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         n = n + {6'd0, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4s_prbs_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_prbs_rx_monitor
// Purpose  : Checker-stream monitor: frame alignment check, error/frame counts.
// Revision : 1.0
// ============================================================================
module axi4s_prbs_rx_monitor
   import lfsr_pkg::*;
#(
   parameter int TDATA_WIDTH = 8,
   parameter int LEN_WIDTH   = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   clear,
   input  logic                   enable,
   input  logic [LEN_WIDTH-1:0]   frame_len,
   input  logic                   chk_tvalid,
   input  logic [TDATA_WIDTH-1:0] chk_tdata,
   input  logic                   chk_tlast,
   output logic [CNT_WIDTH-1:0]   rx_frame_cnt,
   output logic [CNT_WIDTH-1:0]   err_beat_cnt,
   output logic [CNT_WIDTH-1:0]   err_bit_cnt,
   output logic                   align_err
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   logic [LEN_WIDTH-1:0] idx_q, idx_d;
   logic [CNT_WIDTH-1:0] rx_frame_cnt_q, rx_frame_cnt_d;
   logic [CNT_WIDTH-1:0] err_beat_cnt_q, err_beat_cnt_d;
   logic [CNT_WIDTH-1:0] err_bit_cnt_q, err_bit_cnt_d;
   logic                 align_err_q, align_err_d;

   logic                 beat;
   logic                 last_exp;
   logic [6:0]           pop;
   logic [CNT_WIDTH:0]   bit_sum;

   always_comb begin
      idx_d          = idx_q;
      rx_frame_cnt_d = rx_frame_cnt_q;
      err_beat_cnt_d = err_beat_cnt_q;
      err_bit_cnt_d  = err_bit_cnt_q;
      align_err_d    = align_err_q;
      beat           = enable & chk_tvalid;
      last_exp       = (idx_q == frame_len - LEN_ONE);
      pop            = popcount(POP_MAX_W'(chk_tdata));
      bit_sum        = {1'b0, err_bit_cnt_q} + (CNT_WIDTH+1)'(pop);
      if (clear) begin
         idx_d          = '0;
         rx_frame_cnt_d = '0;
         err_beat_cnt_d = '0;
         err_bit_cnt_d  = '0;
         align_err_d    = 1'b0;
      end else if (beat) begin
         // Either an early tlast or the expected boundary resyncs the index.
         idx_d = (chk_tlast || last_exp) ? '0 : idx_q + LEN_ONE;
         if (chk_tlast != last_exp) begin
            align_err_d = 1'b1;
         end
         if (chk_tlast && rx_frame_cnt_q != CNT_MAX) begin
            rx_frame_cnt_d = rx_frame_cnt_q + CNT_ONE;
         end
         if (chk_tdata != '0 && err_beat_cnt_q != CNT_MAX) begin
            err_beat_cnt_d = err_beat_cnt_q + CNT_ONE;
         end
         err_bit_cnt_d = bit_sum[CNT_WIDTH] ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         idx_q          <= '0;
         rx_frame_cnt_q <= '0;
         err_beat_cnt_q <= '0;
         err_bit_cnt_q  <= '0;
         align_err_q    <= 1'b0;
      end else begin
         idx_q          <= idx_d;
         rx_frame_cnt_q <= rx_frame_cnt_d;
         err_beat_cnt_q <= err_beat_cnt_d;
         err_bit_cnt_q  <= err_bit_cnt_d;
         align_err_q    <= align_err_d;
      end
   end

   assign rx_frame_cnt = rx_frame_cnt_q;
   assign err_beat_cnt = err_beat_cnt_q;
   assign err_bit_cnt  = err_bit_cnt_q;
   assign align_err    = align_err_q;

endmodule
`default_nettype wire

// File: rtl/axi4s_prbs_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_prbs_ctrl
// Purpose  : PRBS link-test sequencer (tx framing, drain timer) and monitor.
// Revision : 1.0
// ============================================================================
module axi4s_prbs_ctrl
   import lfsr_pkg::*;
#(
   parameter int TDATA_WIDTH   = 8,
   parameter int LEN_WIDTH     = 16,
   parameter int CNT_WIDTH     = 32,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   cfg_start,
   input  logic                   cfg_stop,
   input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
   input  logic [CNT_WIDTH-1:0]   cfg_num_frames,
   output logic                   gen_tvalid,
   input  logic                   gen_tready,
   output logic [TDATA_WIDTH-1:0] gen_tdata,
   output logic                   gen_tlast,
   input  logic                   chk_tvalid,
   output logic                   chk_tready,
   input  logic [TDATA_WIDTH-1:0] chk_tdata,
   input  logic                   chk_tlast,
   output logic                   status_busy,
   output logic                   status_done,
   output logic                   status_timeout,
   output logic                   status_align_err,
   output logic [CNT_WIDTH-1:0]   tx_frame_cnt,
   output logic [CNT_WIDTH-1:0]   rx_frame_cnt,
   output logic [CNT_WIDTH-1:0]   err_beat_cnt,
   output logic [CNT_WIDTH-1:0]   err_bit_cnt
);

   localparam int               DCW        = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
   localparam logic [DCW-1:0]   DCNT_ONE   = DCW'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH:0]   CNT_ONE_X = (CNT_WIDTH+1)'(1);

   prbs_ctrl_state_t       state_q, state_d;
   logic [LEN_WIDTH-1:0]   frame_len_q, frame_len_d;
   logic [CNT_WIDTH-1:0]   num_frames_q, num_frames_d;
   logic [LEN_WIDTH-1:0]   tx_idx_q, tx_idx_d;
   logic [CNT_WIDTH-1:0]   tx_frame_cnt_q, tx_frame_cnt_d;
   logic                   stop_pending_q, stop_pending_d;
   logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;

   logic                   start_acc;
   logic                   tx_hs;
   logic                   last_frame;
   logic [CNT_WIDTH:0]     tx_next_cnt;

   assign gen_tvalid  = (state_q == RUN);
   assign gen_tlast   = gen_tvalid && (tx_idx_q == frame_len_q - LEN_ONE);
   assign gen_tdata   = '0;
   assign chk_tready  = 1'b1;
   assign tx_hs       = gen_tvalid & gen_tready;
   assign start_acc   = (state_q == IDLE) & cfg_start;
   assign tx_next_cnt = {1'b0, tx_frame_cnt_q} + CNT_ONE_X;
   assign last_frame  = (num_frames_q != '0) && (tx_next_cnt == {1'b0, num_frames_q});

   always_comb begin
      state_d        = state_q;
      frame_len_d    = frame_len_q;
      num_frames_d   = num_frames_q;
      tx_idx_d       = tx_idx_q;
      tx_frame_cnt_d = tx_frame_cnt_q;
      stop_pending_d = stop_pending_q;
      drain_cnt_d    = drain_cnt_q;
      done_d         = done_q;
      timeout_d      = timeout_q;
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               frame_len_d    = (cfg_frame_len == '0) ? LEN_ONE : cfg_frame_len;
               num_frames_d   = cfg_num_frames;
               tx_idx_d       = '0;
               tx_frame_cnt_d = '0;
               stop_pending_d = 1'b0;
               drain_cnt_d    = '0;
               done_d         = 1'b0;
               timeout_d      = 1'b0;
               state_d        = RUN;
            end
         end
         RUN: begin
            if (cfg_stop) begin
               stop_pending_d = 1'b1;
            end
            if (tx_hs) begin
               if (gen_tlast) begin
                  tx_idx_d = '0;
                  if (tx_frame_cnt_q != CNT_MAX) begin
                     tx_frame_cnt_d = tx_next_cnt[CNT_WIDTH-1:0];
                  end
                  // A stop arriving on the closing beat ends the run here.
                  if (last_frame || stop_pending_q || cfg_stop) begin
                     state_d     = DRAIN;
                     drain_cnt_d = '0;
                  end
               end else begin
                  tx_idx_d = tx_idx_q + LEN_ONE;
               end
            end
         end
         DRAIN: begin
            if (rx_frame_cnt == tx_frame_cnt_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end else if (chk_tvalid) begin
               drain_cnt_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + DCNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q        <= IDLE;
         frame_len_q    <= '0;
         num_frames_q   <= '0;
         tx_idx_q       <= '0;
         tx_frame_cnt_q <= '0;
         stop_pending_q <= 1'b0;
         drain_cnt_q    <= '0;
         done_q         <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_len_q    <= frame_len_d;
         num_frames_q   <= num_frames_d;
         tx_idx_q       <= tx_idx_d;
         tx_frame_cnt_q <= tx_frame_cnt_d;
         stop_pending_q <= stop_pending_d;
         drain_cnt_q    <= drain_cnt_d;
         done_q         <= done_d;
         timeout_q      <= timeout_d;
      end
   end

   axi4s_prbs_rx_monitor #(
      .TDATA_WIDTH (TDATA_WIDTH),
      .LEN_WIDTH   (LEN_WIDTH),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_rx_monitor (
      .aclk         (aclk),
      .areset       (areset),
      .clear        (start_acc),
      .enable       (state_q != IDLE),
      .frame_len    (frame_len_q),
      .chk_tvalid   (chk_tvalid),
      .chk_tdata    (chk_tdata),
      .chk_tlast    (chk_tlast),
      .rx_frame_cnt (rx_frame_cnt),
      .err_beat_cnt (err_beat_cnt),
      .err_bit_cnt  (err_bit_cnt),
      .align_err    (status_align_err)
   );

   assign status_busy    = (state_q != IDLE);
   assign status_done    = done_q;
   assign status_timeout = timeout_q;
   assign tx_frame_cnt   = tx_frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4s_prbs_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi4s_prbs_ctrl
// Purpose  : Self-checking bench with an ideal generator->checker loopback.
// Revision : 1.0
// ============================================================================
module tb_axi4s_prbs_ctrl;

   localparam int TW = 8;
   localparam int LW = 16;
   localparam int CW = 32;
   localparam int DT = 16;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          cfg_start = 1'b0;
   logic          cfg_stop = 1'b0;
   logic [LW-1:0] cfg_frame_len = '0;
   logic [CW-1:0] cfg_num_frames = '0;
   logic          gen_tvalid;
   logic          gen_tready = 1'b0;
   logic [TW-1:0] gen_tdata;
   logic          gen_tlast;
   logic          chk_tvalid = 1'b0;
   logic          chk_tready;
   logic [TW-1:0] chk_tdata = '0;
   logic          chk_tlast = 1'b0;
   logic          status_busy, status_done, status_timeout, status_align_err;
   logic [CW-1:0] tx_frame_cnt, rx_frame_cnt, err_beat_cnt, err_bit_cnt;

   always #5 aclk = ~aclk;

   axi4s_prbs_ctrl #(
      .TDATA_WIDTH(TW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .DRAIN_TIMEOUT(DT)
   ) dut (
      .aclk(aclk), .areset(areset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_frame_len(cfg_frame_len), .cfg_num_frames(cfg_num_frames),
      .gen_tvalid(gen_tvalid), .gen_tready(gen_tready), .gen_tdata(gen_tdata),
      .gen_tlast(gen_tlast), .chk_tvalid(chk_tvalid), .chk_tready(chk_tready),
      .chk_tdata(chk_tdata), .chk_tlast(chk_tlast), .status_busy(status_busy),
      .status_done(status_done), .status_timeout(status_timeout),
      .status_align_err(status_align_err), .tx_frame_cnt(tx_frame_cnt),
      .rx_frame_cnt(rx_frame_cnt), .err_beat_cnt(err_beat_cnt), .err_bit_cnt(err_bit_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   // Loopback / stimulus control
   int     flen_eff = 1;
   int     tready_mode = 0;   // 0 always ready, 1 random, 2 toggle
   int     chk_mode = 0;      // 0 immediate, 1 random latency, 2 hold invalid
   int     err_at = -1;
   logic [7:0] err_val = '0;
   bit     rand_err = 0;
   int     bad_last_at = -1;
   int     rx_no = 0;
   int     beats_seen = 0;
   logic   txq[$];
   longint m_eb = 0;
   longint m_ebit = 0;
   bit     prev_stall = 0;
   logic   prev_tlast = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Generator side: observe the handshake that the coming edge will complete.
   always @(negedge aclk) begin
      if (!areset) begin
         if (prev_stall) begin
            check("stall_tvalid", 64'(gen_tvalid), 64'd1);
            check("stall_tlast", 64'(gen_tlast), 64'(prev_tlast));
         end
         prev_stall = gen_tvalid && !gen_tready;
         prev_tlast = gen_tlast;
         if (gen_tvalid && gen_tready) begin
            check("tx_tlast_pos", 64'(gen_tlast), 64'((beats_seen % flen_eff) == flen_eff - 1));
            check("gen_tdata", 64'(gen_tdata), 64'd0);
            txq.push_back(gen_tlast);
            beats_seen++;
         end
      end else begin
         prev_stall = 0;
      end
   end

   // Ideal checker output plus error / tlast injection; tallies the model.
   always @(posedge aclk) begin
      #1;
      case (tready_mode)
         0:       gen_tready = 1'b1;
         1:       gen_tready = 1'($urandom % 2);
         default: gen_tready = !gen_tready;
      endcase
      chk_tvalid = 1'b0;
      chk_tdata  = '0;
      chk_tlast  = 1'b0;
      if (txq.size() > 0 && chk_mode != 2 && (chk_mode == 0 || ($urandom % 4) != 0)) begin
         chk_tvalid = 1'b1;
         chk_tlast  = txq.pop_front();
         if (rx_no == err_at) chk_tdata = err_val;
         else if (rand_err && ($urandom % 4) == 0) chk_tdata = 8'($urandom);
         if (bad_last_at >= 0) begin
            if (rx_no == bad_last_at) chk_tlast = 1'b1;
            else if (rx_no == bad_last_at + 1) chk_tlast = 1'b0;
         end
         if (chk_tdata != 0) m_eb++;
         m_ebit += $countones(chk_tdata);
         rx_no++;
      end
   end

   task automatic start_run(input int fl, input int nf);
      flen_eff   = (fl == 0) ? 1 : fl;
      beats_seen = 0;
      rx_no      = 0;
      m_eb       = 0;
      m_ebit     = 0;
      cfg_frame_len  = LW'(fl);
      cfg_num_frames = CW'(nf);
      @(posedge aclk); #2 cfg_start = 1'b1;
      @(posedge aclk); #2 cfg_start = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge aclk);
         if (status_done && !status_busy) begin
            ok = 1;
            break;
         end
      end
      check("run_completes", 64'(ok), 64'd1);
   endtask

   task automatic check_results(input string tag, input longint etx, input longint erx,
                                input longint eeb, input longint eebit, input int ebeats,
                                input bit ealign);
      check({tag, ".tx_frames"}, 64'(tx_frame_cnt), 64'(etx));
      check({tag, ".rx_frames"}, 64'(rx_frame_cnt), 64'(erx));
      check({tag, ".err_beats"}, 64'(err_beat_cnt), 64'(eeb));
      check({tag, ".err_bits"}, 64'(err_bit_cnt), 64'(eebit));
      check({tag, ".gen_beats"}, 64'(beats_seen), 64'(ebeats));
      check({tag, ".align_err"}, 64'(status_align_err), 64'(ealign));
      check({tag, ".timeout"}, 64'(status_timeout), 64'd0);
      check({tag, ".gen_tvalid_idle"}, 64'(gen_tvalid), 64'd0);
      check({tag, ".rx_queue_empty"}, 64'(txq.size()), 64'd0);
   endtask

   typedef struct {
      int fl; int nf; int trdy; int cmode; int eat; int eval;
      int etx; int erx; int eeb; int eebit; int ebeats;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #500000;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      tbl[0] = '{4, 3, 0, 0, -1, 8'h00, 3, 3, 0, 0, 12};
      tbl[1] = '{4, 3, 0, 0,  5, 8'h05, 3, 3, 1, 2, 12};
      tbl[2] = '{4, 3, 2, 0, -1, 8'h00, 3, 3, 0, 0, 12};
      tbl[3] = '{0, 2, 1, 1,  1, 8'hFF, 2, 2, 1, 8, 2};
      tbl[4] = '{5, 2, 2, 1,  7, 8'h81, 2, 2, 1, 2, 10};

      repeat (3) @(posedge aclk);
      #3;
      check("rst.gen_tvalid", 64'(gen_tvalid), 64'd0);
      check("rst.gen_tlast", 64'(gen_tlast), 64'd0);
      check("rst.chk_tready", 64'(chk_tready), 64'd1);
      check("rst.busy", 64'(status_busy), 64'd0);
      check("rst.done", 64'(status_done), 64'd0);
      check("rst.tx_frames", 64'(tx_frame_cnt), 64'd0);
      check("rst.err_bits", 64'(err_bit_cnt), 64'd0);
      areset = 1'b0;

      foreach (tbl[i]) begin
         tready_mode = tbl[i].trdy;
         chk_mode    = tbl[i].cmode;
         err_at      = tbl[i].eat;
         err_val     = 8'(tbl[i].eval);
         rand_err    = 0;
         bad_last_at = -1;
         start_run(tbl[i].fl, tbl[i].nf);
         check("tbl.busy_after_start", 64'(status_busy), 64'd1);
         wait_done();
         check_results("tbl", tbl[i].etx, tbl[i].erx, tbl[i].eeb, tbl[i].eebit,
                       tbl[i].ebeats, 1'b0);
      end
      err_at = -1;

      // Randomised runs against the loopback model.
      for (int r = 0; r < 6; r++) begin
         int fl, nf;
         fl = $urandom_range(1, 6);
         nf = $urandom_range(1, 4);
         tready_mode = $urandom_range(0, 2);
         chk_mode    = $urandom_range(0, 1);
         rand_err    = 1;
         start_run(fl, nf);
         wait_done();
         check_results("rand", nf, nf, m_eb, m_ebit, fl * nf, 1'b0);
      end
      rand_err = 0;

      // Continuous run stopped mid-frame: the frame must complete.
      tready_mode = 0;
      chk_mode    = 0;
      start_run(8, 0);
      for (int k = 0; k < 200 && beats_seen < 10; k++) @(negedge aclk);
      @(posedge aclk); #2 cfg_stop = 1'b1;
      @(posedge aclk); #2 cfg_stop = 1'b0;
      wait_done();
      check_results("stop", 2, 2, 0, 0, 16, 1'b0);

      // Checker tlast moved one beat early.
      bad_last_at = 2;
      start_run(4, 3);
      wait_done();
      check_results("align", 3, 3, 0, 0, 12, 1'b1);
      bad_last_at = -1;

      // Checker silent: drain must time out DT cycles after the last tx tlast.
      begin
         int k;
         bit seen;
         chk_mode = 2;
         start_run(4, 1);
         seen = 0;
         for (int j = 0; j < 200; j++) begin
            @(negedge aclk);
            if (gen_tvalid && gen_tready && gen_tlast) begin
               seen = 1;
               break;
            end
         end
         check("tmo.final_tlast_seen", 64'(seen), 64'd1);
         @(posedge aclk);
         k = 0;
         for (int j = 0; j < 100; j++) begin
            @(negedge aclk);
            if (status_timeout) break;
            @(posedge aclk);
            k++;
         end
         check("tmo.cycles", 64'(k), 64'(DT));
         check("tmo.timeout", 64'(status_timeout), 64'd1);
         check("tmo.done", 64'(status_done), 64'd1);
         check("tmo.busy", 64'(status_busy), 64'd0);
         check("tmo.tx_frames", 64'(tx_frame_cnt), 64'd1);
         check("tmo.rx_frames", 64'(rx_frame_cnt), 64'd0);
         txq.delete();
         chk_mode = 0;
      end

      // Asynchronous reset in the middle of a run.
      rand_err = 1;
      start_run(2, 0);
      repeat (9) @(posedge aclk);
      #3 areset = 1'b1;
      #1;
      check("arst.gen_tvalid", 64'(gen_tvalid), 64'd0);
      check("arst.busy", 64'(status_busy), 64'd0);
      check("arst.tx_frames", 64'(tx_frame_cnt), 64'd0);
      check("arst.rx_frames", 64'(rx_frame_cnt), 64'd0);
      check("arst.err_beats", 64'(err_beat_cnt), 64'd0);
      check("arst.err_bits", 64'(err_bit_cnt), 64'd0);
      check("arst.chk_tready", 64'(chk_tready), 64'd1);
      rand_err = 0;
      @(posedge aclk);
      #3 areset = 1'b0;
      txq.delete();
      repeat (2) @(posedge aclk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi4s_prbs_ctrl.md
Name: axi4s_prbs_ctrl

Overview:
Sequencer and monitor for one PRBS test link. It drives framed all-zero beats into an axi4s_lfsr generator (CHK_NOT_GEN=0) and receives the output stream of an axi4s_lfsr checker (CHK_NOT_GEN=1). Any nonzero checker beat is a bit error; the block counts bit errors, beat errors and frame-alignment errors. It sits between a register bank (cfg/status ports) and the generator/checker pair in a BIST or link-test top.

Parameters:
TDATA_WIDTH, 8, data width of both streams; must match the LFSR blocks
LEN_WIDTH, 16, width of cfg_frame_len
CNT_WIDTH, 32, width of all counters and cfg_num_frames
DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN before aborting; must be >= 1

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
cfg_start  in  1  single-cycle pulse; starts a run
cfg_stop  in  1  single-cycle pulse; ends the run at the next frame boundary
cfg_frame_len  in  LEN_WIDTH  beats per frame; 0 is treated as 1
cfg_num_frames  in  CNT_WIDTH  frames per run; 0 means continuous until stop
gen_tvalid  out  1  to generator target_tvalid
gen_tready  in  1  from generator target_tready
gen_tdata  out  TDATA_WIDTH  constant 0
gen_tlast  out  1  marks the last beat of each frame
chk_tvalid  in  1  from checker initiator_tvalid
chk_tready  out  1  constant 1
chk_tdata  in  TDATA_WIDTH  checker output; nonzero means error
chk_tlast  in  1  checker tlast
status_busy  out  1  high in RUN and DRAIN
status_done  out  1  sticky; set on entering IDLE from DRAIN; cleared by start
status_timeout  out  1  sticky; set when DRAIN times out; cleared by start
status_align_err  out  1  sticky; set on tlast mismatch; cleared by start
tx_frame_cnt  out  CNT_WIDTH  frames accepted by the generator
rx_frame_cnt  out  CNT_WIDTH  checker beats seen with tlast
err_beat_cnt  out  CNT_WIDTH  checker beats with nonzero data
err_bit_cnt  out  CNT_WIDTH  sum of popcount(chk_tdata) over all beats

Behaviour:
- Reset: state=IDLE. All outputs are 0, except chk_tready, which is 1.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, cfg_start high: latch frame_len (0 becomes 1) and num_frames, clear all counters and sticky flags, go to RUN. gen_tvalid rises the next cycle.
- cfg_start is ignored outside IDLE.
- RUN:
  - gen_tvalid is held at 1 and never drops while a beat is pending.
  - The tx beat index increments on each gen_tvalid&gen_tready handshake.
  - gen_tlast=1 when beat index == frame_len-1. The index wraps to 0 on the tlast handshake, and tx_frame_cnt increments.
  - cfg_stop in RUN sets a stop_pending flag.
  - RUN goes to DRAIN on the tlast handshake when tx_frame_cnt+1 == num_frames (num_frames != 0) or stop_pending is set. gen_tvalid drops that same edge.
  - If cfg_stop and the final tlast handshake coincide, go to DRAIN with no extra frame.
  - Frames are never truncated.
- DRAIN:
  - Clear the timeout counter on entry and on every rx handshake.
  - Go to IDLE with status_done=1 when rx_frame_cnt == tx_frame_cnt, checked on the registered counts.
  - If the counter reaches DRAIN_TIMEOUT first, go to IDLE with status_timeout=1 and status_done=1.
- Rx monitor:
  - Active in RUN and DRAIN. chk beats are accepted in IDLE too, but counters do not change.
  - On each chk_tvalid beat, err_bit_cnt += popcount(chk_tdata), and err_beat_cnt += 1 if chk_tdata != 0.
  - The rx beat index compares to frame_len-1. If chk_tlast disagrees with (index == frame_len-1), set status_align_err.
  - The rx index resets to 0 on chk_tlast and on index == frame_len-1, whichever comes first (resync).
  - rx_frame_cnt increments on chk_tlast.
- All counters saturate at all-ones; there is no wrap.
- Async reset mid-run returns to IDLE immediately and drops gen_tvalid. The upstream LFSR blocks are reset together.
- Counter outputs are registered and updated one cycle after the handshake.

Decomposition:
- lfsr_pkg gains: typedef enum prbs_ctrl_state_t {IDLE, RUN, DRAIN}; function popcount.
- One sub-module, axi4s_prbs_rx_monitor. It contains the rx index, align check and error/frame counters. Inputs: clear, enable, frame_len, chk stream. Outputs: counters and align flag.
- The top holds the FSM, the tx sequencer and the drain timer.

Test Plan:
- frame_len=4, num_frames=3, gen_tready=1, looped through ideal generator→checker: exactly 12 gen beats, tlast on beats 3/7/11, tx=rx=3, err_beat=err_bit=0, done=1, busy low.
- Same config, checker tdata forced to 0x05 on rx beat 5: err_beat_cnt=1, err_bit_cnt=2, status_align_err=0.
- num_frames=0, frame_len=8, cfg_stop pulsed at tx beat 10: run ends after beat 15 (tlast), tx_frame_cnt=2, no beat 16 issued.
- gen_tready toggled 1/0 every cycle: gen_tvalid and gen_tlast stay stable while stalled, and the counts match the first test.
- Checker delivers tlast at beat 2 with frame_len=4: status_align_err=1, rx index resyncs, and the next correctly aligned frame raises no further errors.
- DRAIN_TIMEOUT=16, checker output held invalid: 16 cycles after the final tx tlast, status_timeout=1, done=1, state IDLE.
- Areset asserted mid-RUN: gen_tvalid and all counters are 0 within the same cycle.
